serial_addsub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor. Each cycle it processes DIGIT bits of two WIDTH-bit operands, LSB first, through a ripple slice of full-adder cells and a registered carry.
- Successor to the single-bit combinational full adder. Adds operand width, subtract mode, signed overflow and a start/busy/done handshake.
- Sits in the datapath, where area matters more than latency; used by ALU and accumulator blocks.

---
 rtl/serial_addsub_pkg.sv | 34 +++
 rtl/serial_addsub_slice.sv | 35 +++
 rtl/serial_addsub.sv | 141 ++++++++++++++
 tb/tb_serial_addsub.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   state_t            FSM encoding (IDLE, RUN, DONE)
//   MODE_ADD/MODE_SUB  values of the 'sub' input
//   calc_n/calc_cnt_w  derive the digit count and counter width
//   N, CNT_W           values for the default 8-bit, 1-bit-digit build
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of processing cycles for an operation; guarded so a bad DIGIT
  // reaches the elaboration check instead of dividing by zero.
  function automatic int calc_n(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // Counter needs to reach n-1; a single-digit operation still gets one bit.
  function automatic int calc_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGIT = 1;
  localparam int N     = calc_n(DEFAULT_WIDTH, DEFAULT_DIGIT);
  localparam int CNT_W = calc_cnt_w(N);

endpackage

// File: rtl/serial_addsub_slice.sv
// addsub_slice
// Combinational DIGIT-bit ripple of full-adder cells.
//   x, y      operand digits
//   cin       carry into bit 0
//   s         digit sum
//   cout      carry out of the top bit
//   c_msb_in  carry into the top bit (pairs with cout for signed overflow)
module addsub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] carry_chain;

  // Classic ripple: each cell consumes the carry produced by the cell below.
  always_comb begin
    carry_chain    = '0;
    s              = '0;
    carry_chain[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]             = x[i] ^ y[i] ^ carry_chain[i];
      carry_chain[i+1] = (x[i] & y[i]) | (carry_chain[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = carry_chain[DIGIT];
  assign c_msb_in = carry_chain[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Multi-cycle adder/subtractor processing DIGIT bits per clock, LSB first.
// Subtraction is a + ~b + 1, done by inverting B and seeding the carry.
//   clk, rst        clock, asynchronous active-high reset
//   start, sub      request an operation (sampled in IDLE/DONE), 1 = a-b
//   a, b            operands, sampled with start
//   busy            operation in progress
//   done            one-cycle result-valid pulse
//   sum, cout       result and carry (1 = no borrow when subtracting)
//   overflow        two's-complement overflow
// Results only update on the final digit, so partial sums never show.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NUM_DIGITS = calc_n(WIDTH, DIGIT);
  localparam int CNT_WIDTH  = calc_cnt_w(NUM_DIGITS);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_DIGITS - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
  end

  state_t state, state_next;

  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     res_reg;
  logic [WIDTH-1:0]     res_next;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry;
  logic                 cout_q;
  logic                 ovf_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic [DIGIT-1:0]     slice_s;
  logic                 slice_cout;
  logic                 slice_c_msb;
  logic                 last_digit;
  logic                 accept;

  addsub_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x        (a_reg[DIGIT-1:0]),
    .y        (b_reg[DIGIT-1:0]),
    .cin      (carry),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  assign last_digit = (cnt == LAST_CNT);
  assign accept     = start && (state == IDLE || state == DONE);

  // New digits enter from the MSB side, so after N shifts the first digit
  // has walked down to bit 0. A single-digit build has nothing to shift.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign res_next = slice_s;
  end else begin : g_multi_digit
    assign res_next = {slice_s, res_reg[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE can go straight back to RUN for back-to-back use.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_digit ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: load on acceptance, shift one digit per RUN cycle, publish the
  // result only on the last digit. Overflow uses the carry into the word's
  // MSB, which on the last digit is the slice's top-bit carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= (sub == MODE_SUB) ? ~b : b;
      carry <= (sub == MODE_SUB);
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg   <= a_reg >> DIGIT;
      b_reg   <= b_reg >> DIGIT;
      res_reg <= res_next;
      carry   <= slice_cout;
      cnt     <= cnt + CNT_WIDTH'(1);
      if (last_digit) begin
        sum_q  <= res_next;
        cout_q <= slice_cout;
        ovf_q  <= slice_cout ^ slice_c_msb;
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Three instances: 8-bit/1-bit digits, 8-bit/4-bit digits, 16-bit/2-bit
// digits. Stimulus pushes expected results into a scoreboard queue; the
// monitor pops one entry per done pulse and checks value and timing.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_i [3];
  logic        sub_i   [3];
  logic [15:0] a_i     [3];
  logic [15:0] b_i     [3];

  logic        busy_w  [3];
  logic        done_w  [3];
  logic        cout_w  [3];
  logic        ovf_w   [3];
  logic [15:0] sum_w   [3];
  logic [7:0]  sum0, sum1;
  logic [15:0] sum2;

  int num_digits [3] = '{8, 2, 8};

  assign sum_w[0] = {8'h00, sum0};
  assign sum_w[1] = {8'h00, sum1};
  assign sum_w[2] = sum2;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
    .a(a_i[0][7:0]), .b(b_i[0][7:0]), .busy(busy_w[0]), .done(done_w[0]),
    .sum(sum0), .cout(cout_w[0]), .overflow(ovf_w[0]));

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
    .a(a_i[1][7:0]), .b(b_i[1][7:0]), .busy(busy_w[1]), .done(done_w[1]),
    .sum(sum1), .cout(cout_w[1]), .overflow(ovf_w[1]));

  serial_addsub #(.WIDTH(16), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]),
    .a(a_i[2]), .b(b_i[2]), .busy(busy_w[2]), .done(done_w[2]),
    .sum(sum2), .cout(cout_w[2]), .overflow(ovf_w[2]));

  typedef struct {
    int          dut;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_item;
  int   total = 0;
  int   bad   = 0;

  // Single comparison point: every check steps total, failures step bad.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: dut %0d pulsed done with empty scoreboard", i);
        end else begin
          mon_item = sbq.pop_front();
          checkOutput({mon_item.name, "_dut"},   i,             mon_item.dut);
          checkOutput({mon_item.name, "_sum"},   sum_w[i],      mon_item.sum);
          checkOutput({mon_item.name, "_cout"},  cout_w[i],     mon_item.cout);
          checkOutput({mon_item.name, "_ovf"},   ovf_w[i],      mon_item.ovf);
          checkOutput({mon_item.name, "_cycle"}, cyc,           mon_item.due);
        end
      end
    end
  end

  // Drive one request starting at a negedge; returns #1 after the accepting
  // edge with start dropped. Caller guarantees the DUT is in IDLE or DONE.
  task automatic applyStimulus(input int d, input logic [15:0] av,
                               input logic [15:0] bv, input logic sv,
                               input logic [15:0] es, input logic ec,
                               input logic eo, input string name);
    exp_t item;
    start_i[d] = 1'b1;
    a_i[d]     = av;
    b_i[d]     = bv;
    sub_i[d]   = sv;
    @(posedge clk);
    #1;
    item.dut  = d;
    item.sum  = es;
    item.cout = ec;
    item.ovf  = eo;
    item.due  = cyc + num_digits[d];
    item.name = name;
    sbq.push_back(item);
    start_i[d] = 1'b0;
  endtask

  // Returns at the negedge where done is high (DONE cycle).
  task automatic waitDone(input int d, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_w[d] !== 1'b1 && n < 40);
    if (done_w[d] !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: done never rose on dut %0d", name, d);
    end
  endtask

  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic sv, output logic [15:0] s,
                                output logic c, output logic o);
    logic [16:0] r;
    if (!sv) r = {1'b0, av} + {1'b0, bv};
    else     r = {1'b0, av} - {1'b0, bv};
    s = r[15:0];
    c = sv ? ~r[16] : r[16];
    if (!sv) o = (av[15] == bv[15]) && (s[15] != av[15]);
    else     o = (av[15] != bv[15]) && (s[15] != av[15]);
  endfunction

  initial begin
    logic [15:0] ra, rb, rs;
    logic        rsub, rc, ro;

    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      sub_i[i]   = 1'b0;
      a_i[i]     = '0;
      b_i[i]     = '0;
    end

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset_busy", busy_w[i], 0);
      checkOutput("reset_done", done_w[i], 0);
      checkOutput("reset_sum",  sum_w[i],  0);
      checkOutput("reset_cout", cout_w[i], 0);
      checkOutput("reset_ovf",  ovf_w[i],  0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic add and subtract on the bit-serial build.
    applyStimulus(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, "add_5a_3c");
    @(negedge clk);
    checkOutput("busy_in_run", busy_w[0], 1);
    waitDone(0, "add_5a_3c");
    @(negedge clk);
    checkOutput("idle_busy", busy_w[0], 0);
    checkOutput("idle_sum_hold", sum_w[0], 16'h96);

    applyStimulus(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, "add_ff_01");
    waitDone(0, "add_ff_01");
    @(negedge clk);
    applyStimulus(0, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0, 1'b0, "sub_10_20");
    waitDone(0, "sub_10_20");
    @(negedge clk);

    // Four-bit digits: two cycles per operation.
    applyStimulus(1, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, "sub_80_01");
    waitDone(1, "sub_80_01");
    @(negedge clk);

    // Start pulses and operand churn while busy must be ignored.
    applyStimulus(0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0, "ignore_busy");
    @(negedge clk);
    start_i[0] = 1'b1; a_i[0] = 16'hFF; b_i[0] = 16'hFF; sub_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0; a_i[0] = 16'hAA;
    @(negedge clk);
    start_i[0] = 1'b1; b_i[0] = 16'h55;
    @(negedge clk);
    start_i[0] = 1'b0;
    waitDone(0, "ignore_busy");

    // Back-to-back: start asserted during DONE, old sum holds while running.
    applyStimulus(0, 16'h70, 16'h10, 1'b0, 16'h80, 1'b0, 1'b1, "back_to_back");
    @(negedge clk);
    checkOutput("b2b_busy", busy_w[0], 1);
    checkOutput("b2b_sum_hold", sum_w[0], 16'h46);
    repeat (3) @(negedge clk);
    checkOutput("b2b_sum_hold_late", sum_w[0], 16'h46);
    waitDone(0, "back_to_back");
    @(negedge clk);

    // Reset in the third RUN cycle abandons the operation.
    applyStimulus(0, 16'h33, 16'h44, 1'b0, 16'h77, 1'b0, 1'b0, "aborted");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sbq.pop_back());
    #1;
    checkOutput("midrun_rst_busy", busy_w[0], 0);
    checkOutput("midrun_rst_done", done_w[0], 0);
    checkOutput("midrun_rst_sum",  sum_w[0],  0);
    checkOutput("midrun_rst_cout", cout_w[0], 0);
    checkOutput("midrun_rst_ovf",  ovf_w[0],  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(0, 16'h01, 16'h01, 1'b0, 16'h02, 1'b0, 1'b0, "after_reset");
    waitDone(0, "after_reset");
    @(negedge clk);

    // Random operations on the 16-bit build, mixing idle gaps and chaining.
    for (int n = 0; n < 1000; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rsub = 1'($urandom_range(0, 1));
      model(ra, rb, rsub, rs, rc, ro);
      applyStimulus(2, ra, rb, rsub, rs, rc, ro, "random");
      waitDone(2, "random");
      if ($urandom_range(0, 3) != 0) @(negedge clk);
    end
    @(negedge clk);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
